// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if -- bundle of the pipeline, debug and data-memory signals
// around the data memory arbiter.
//   slave  : arbiter side (takes requests and M_RD, drives grants and memory controls)
//   master : environment side (pipeline, debug port and memory model)
// Pipeline: P_Req, P_WE, P_A, P_WD -> P_RD, P_Stall
// Debug   : D_Valid, D_WE, D_A, D_WD -> D_Ready, D_RD, D_RDValid
// Memory  : M_A, M_WD, M_WE -> M_RD (combinational read)
interface data_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  P_Req;
    logic                  P_WE;
    logic [ADDR_WIDTH-1:0] P_A;
    logic [DATA_WIDTH-1:0] P_WD;
    logic [DATA_WIDTH-1:0] P_RD;
    logic                  P_Stall;

    logic                  D_Valid;
    logic                  D_WE;
    logic [ADDR_WIDTH-1:0] D_A;
    logic [DATA_WIDTH-1:0] D_WD;
    logic                  D_Ready;
    logic [DATA_WIDTH-1:0] D_RD;
    logic                  D_RDValid;

    logic [ADDR_WIDTH-1:0] M_A;
    logic [DATA_WIDTH-1:0] M_WD;
    logic                  M_WE;
    logic [DATA_WIDTH-1:0] M_RD;

    modport slave (
        input  P_Req, P_WE, P_A, P_WD, D_Valid, D_WE, D_A, D_WD, M_RD,
        output P_RD, P_Stall, D_Ready, D_RD, D_RDValid, M_A, M_WD, M_WE
    );

    modport master (
        output P_Req, P_WE, P_A, P_WD, D_Valid, D_WE, D_A, D_WD, M_RD,
        input  P_RD, P_Stall, D_Ready, D_RD, D_RDValid, M_A, M_WD, M_WE
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter -- shares one data memory port between the pipeline memory
// stage and a debug/loader port. Pipeline wins by default; debug is served when
// the pipeline is idle. A debug read returns its data one cycle after transfer.
// Optional macro STARVE_TIMER_EN adds a wait counter that forces a single debug
// grant once debug has waited MAX_WAIT cycles.
// Ports:
//   CLK : clock, rising edge
//   RST : asynchronous active-low reset
//   bus : data_mem_arbiter_if.slave (pipeline, debug and memory signals)
module data_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 8,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    data_mem_arbiter_if.slave    bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PIPE = 2'd1;
    localparam logic [1:0] DBG  = 2'd2;

    // Counter must be able to hold MAX_WAIT
    if (CNT_WIDTH < $clog2(MAX_WAIT + 1)) begin : g_cnt_width_check
        $error("CNT_WIDTH too narrow for MAX_WAIT");
    end

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  pipe_gnt;
    logic                  dbg_gnt;
    logic                  force_gnt;
    logic [ADDR_WIDTH-1:0] m_a_c;
    logic [DATA_WIDTH-1:0] m_wd_c;
    logic                  m_we_c;
    logic [DATA_WIDTH-1:0] d_rd_q;
    logic                  last_rd_q;

`ifdef STARVE_TIMER_EN
    localparam logic [CNT_WIDTH-1:0] WAIT_LIMIT = CNT_WIDTH'(MAX_WAIT);

    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 forced_q;

    // Force only after a full wait, and never twice in a row
    always_comb begin
        force_gnt = bus.D_Valid && (wait_cnt >= WAIT_LIMIT) && !((state == DBG) && forced_q);
    end

    // Starvation counter: counts refused cycles, cleared on transfer or withdrawal
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wait_cnt <= '0;
            forced_q <= 1'b0;
        end else begin
            forced_q <= dbg_gnt && force_gnt;
            if (!bus.D_Valid || dbg_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt < WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + CNT_WIDTH'(1);
            end
        end
    end
`else
    always_comb begin
        force_gnt = 1'b0;
    end
`endif

    // State register: remembers last cycle's grant
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant decision, memory mux and handshake outputs; nothing granted in reset
    always_comb begin
        state_nxt   = IDLE;
        pipe_gnt    = 1'b0;
        dbg_gnt     = 1'b0;
        m_a_c       = '0;
        m_wd_c      = '0;
        m_we_c      = 1'b0;
        bus.D_Ready = 1'b0;
        bus.P_Stall = 1'b0;
        if (RST) begin
            if (bus.P_Req && !force_gnt) begin
                pipe_gnt  = 1'b1;
                state_nxt = PIPE;
                m_a_c     = bus.P_A;
                m_wd_c    = bus.P_WD;
                m_we_c    = bus.P_WE;
            end else if (bus.D_Valid) begin
                dbg_gnt     = 1'b1;
                state_nxt   = DBG;
                m_a_c       = bus.D_A;
                m_wd_c      = bus.D_WD;
                m_we_c      = bus.D_WE;
                bus.D_Ready = 1'b1;
                bus.P_Stall = bus.P_Req;
            end
        end
    end

    // Debug read capture; the valid pulse is the cycle after a debug read grant
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            d_rd_q    <= '0;
            last_rd_q <= 1'b0;
        end else begin
            last_rd_q <= dbg_gnt && !bus.D_WE;
            if (dbg_gnt && !bus.D_WE) begin
                d_rd_q <= bus.M_RD;
            end
        end
    end

    assign bus.M_A       = m_a_c;
    assign bus.M_WD      = m_wd_c;
    assign bus.M_WE      = m_we_c;
    assign bus.P_RD      = bus.M_RD;
    assign bus.D_RD      = d_rd_q;
    assign bus.D_RDValid = (state == DBG) && last_rd_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
    localparam int MAX_WAIT = 8;
`ifdef STARVE_TIMER_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif

    logic CLK;
    logic RST;
    int   total;
    int   bad;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    data_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    data_mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(MAX_WAIT), .CNT_WIDTH(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: combinational read, synchronous write
    assign bus.M_RD = mem[bus.M_A[7:0]];
    always @(posedge CLK) begin
        if (bus.M_WE) mem[bus.M_A[7:0]] <= bus.M_WD;
    end

    task automatic clear_inputs();
        bus.P_Req = 0; bus.P_WE = 0; bus.P_A = '0; bus.P_WD = '0;
        bus.D_Valid = 0; bus.D_WE = 0; bus.D_A = '0; bus.D_WD = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        @(negedge CLK);
        bus.P_Req = 1; bus.P_WE = 1; bus.P_A = 32'h4; bus.P_WD = 32'h1234;
        bus.D_Valid = 1; bus.D_WE = 0; bus.D_A = 32'h8;
        @(posedge CLK); #2;
        total++; if (bus.M_WE !== 1'b0) begin bad++; $display("FAIL reset_m_we got=%b exp=0", bus.M_WE); end
        total++; if (bus.D_Ready !== 1'b0) begin bad++; $display("FAIL reset_d_ready got=%b exp=0", bus.D_Ready); end
        total++; if (bus.P_Stall !== 1'b0) begin bad++; $display("FAIL reset_p_stall got=%b exp=0", bus.P_Stall); end
        total++; if (bus.D_RDValid !== 1'b0) begin bad++; $display("FAIL reset_d_rdvalid got=%b exp=0", bus.D_RDValid); end
        total++; if (bus.D_RD !== 32'h0) begin bad++; $display("FAIL reset_d_rd got=%h exp=0", bus.D_RD); end
        do_reset();
    endtask

    task automatic test_pipe_write();
        @(negedge CLK);
        bus.P_Req = 1; bus.P_WE = 1; bus.P_A = 32'h10; bus.P_WD = 32'hCAFE;
        #2;
        total++; if (bus.M_WE !== 1'b1) begin bad++; $display("FAIL pw_m_we got=%b exp=1", bus.M_WE); end
        total++; if (bus.M_A !== 32'h10) begin bad++; $display("FAIL pw_m_a got=%h exp=10", bus.M_A); end
        total++; if (bus.M_WD !== 32'hCAFE) begin bad++; $display("FAIL pw_m_wd got=%h exp=cafe", bus.M_WD); end
        total++; if (bus.P_Stall !== 1'b0) begin bad++; $display("FAIL pw_p_stall got=%b exp=0", bus.P_Stall); end
        @(negedge CLK);
        clear_inputs();
        #2;
        total++; if (mem[8'h10] !== 32'hCAFE) begin bad++; $display("FAIL pw_mem got=%h exp=cafe", mem[8'h10]); end
    endtask

    task automatic test_dbg_read();
        @(negedge CLK);
        bus.D_Valid = 1; bus.D_WE = 0; bus.D_A = 32'h10;
        #2;
        total++; if (bus.D_Ready !== 1'b1) begin bad++; $display("FAIL dr_ready got=%b exp=1", bus.D_Ready); end
        total++; if (bus.M_WE !== 1'b0) begin bad++; $display("FAIL dr_m_we got=%b exp=0", bus.M_WE); end
        total++; if (bus.D_RDValid !== 1'b0) begin bad++; $display("FAIL dr_early_valid got=%b exp=0", bus.D_RDValid); end
        @(negedge CLK);
        clear_inputs();
        #2;
        total++; if (bus.D_RDValid !== 1'b1) begin bad++; $display("FAIL dr_valid got=%b exp=1", bus.D_RDValid); end
        total++; if (bus.D_RD !== 32'hCAFE) begin bad++; $display("FAIL dr_data got=%h exp=cafe", bus.D_RD); end
        @(negedge CLK); #2;
        total++; if (bus.D_RDValid !== 1'b0) begin bad++; $display("FAIL dr_pulse_end got=%b exp=0", bus.D_RDValid); end
        total++; if (bus.D_RD !== 32'hCAFE) begin bad++; $display("FAIL dr_hold got=%h exp=cafe", bus.D_RD); end
    endtask

    task automatic test_starve();
        do_reset();
`ifdef STARVE_TIMER_EN
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge CLK);
            if (cyc == 1) begin
                bus.P_Req = 1; bus.P_WE = 0; bus.P_A = 32'h20;
                bus.D_Valid = 1; bus.D_WE = 0; bus.D_A = 32'h10;
            end
            #2;
            total++; if (bus.D_Ready !== (cyc == 9)) begin bad++; $display("FAIL st_ready cyc=%0d got=%b exp=%b", cyc, bus.D_Ready, cyc == 9); end
            total++; if (bus.P_Stall !== (cyc == 9)) begin bad++; $display("FAIL st_stall cyc=%0d got=%b exp=%b", cyc, bus.P_Stall, cyc == 9); end
            if (cyc >= 9) begin
                total++; if (bus.M_A !== ((cyc == 9) ? 32'h10 : 32'h20)) begin bad++; $display("FAIL st_addr cyc=%0d got=%h", cyc, bus.M_A); end
            end
        end
`else
        for (int cyc = 1; cyc <= 21; cyc++) begin
            @(negedge CLK);
            if (cyc == 1) begin
                bus.P_Req = 1; bus.P_WE = 0; bus.P_A = 32'h20;
                bus.D_Valid = 1; bus.D_WE = 0; bus.D_A = 32'h10;
            end
            if (cyc == 21) bus.P_Req = 0;
            #2;
            total++; if (bus.D_Ready !== (cyc == 21)) begin bad++; $display("FAIL np_ready cyc=%0d got=%b exp=%b", cyc, bus.D_Ready, cyc == 21); end
            total++; if (bus.P_Stall !== 1'b0) begin bad++; $display("FAIL np_stall cyc=%0d got=%b exp=0", cyc, bus.P_Stall); end
        end
`endif
        @(negedge CLK);
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge CLK);
        bus.D_Valid = 1; bus.D_WE = 0; bus.D_A = 32'h10;
        @(posedge CLK); #1;
        bus.D_Valid = 0;
        bus.P_Req = 1; bus.P_WE = 1; bus.P_A = 32'h30; bus.P_WD = 32'h55;
        #1;
        total++; if (bus.D_RDValid !== 1'b1) begin bad++; $display("FAIL rm_pre_valid got=%b exp=1", bus.D_RDValid); end
        RST = 1'b0;
        #1;
        total++; if (bus.D_RDValid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", bus.D_RDValid); end
        total++; if (bus.D_RD !== 32'h0) begin bad++; $display("FAIL rm_data got=%h exp=0", bus.D_RD); end
        total++; if (bus.M_WE !== 1'b0) begin bad++; $display("FAIL rm_m_we got=%b exp=0", bus.M_WE); end
        repeat (2) @(negedge CLK);
        clear_inputs();
        RST = 1'b1;
    endtask

    task automatic test_random();
        int          waited;
        bit          last_forced;
        bit          forced, pg, dg, exp_we, exp_rdv, done;
        logic [31:0] exp_drd, exp_a;
        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        waited = 0; last_forced = 0; exp_rdv = 0; exp_drd = '0; done = 1;
        for (int n = 0; n < 600; n++) begin
            @(negedge CLK);
            bus.P_Req = ($urandom_range(0, 3) != 0);
            bus.P_WE  = $urandom_range(0, 1);
            bus.P_A   = 32'($urandom_range(0, 31));
            bus.P_WD  = $urandom;
            if (bus.D_Valid && !done && $urandom_range(0, 15) != 0) begin
                // keep the pending debug request
            end else begin
                bus.D_Valid = $urandom_range(0, 1);
                bus.D_WE    = $urandom_range(0, 1);
                bus.D_A     = 32'($urandom_range(0, 31));
                bus.D_WD    = $urandom;
            end
            #2;
            forced = STARVE && bus.D_Valid && (waited >= MAX_WAIT) && !last_forced;
            pg     = bus.P_Req && !forced;
            dg     = bus.D_Valid && !pg;
            exp_we = pg ? bus.P_WE : (dg ? bus.D_WE : 1'b0);
            exp_a  = pg ? bus.P_A : (dg ? bus.D_A : 32'h0);
            total++; if (bus.D_Ready !== dg) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, bus.D_Ready, dg); end
            total++; if (bus.P_Stall !== (bus.P_Req && dg)) begin bad++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, bus.P_Stall, bus.P_Req && dg); end
            total++; if (bus.M_WE !== exp_we) begin bad++; $display("FAIL rnd_we n=%0d got=%b exp=%b", n, bus.M_WE, exp_we); end
            if (pg || dg) begin
                total++; if (bus.M_A !== exp_a) begin bad++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, bus.M_A, exp_a); end
            end
            total++; if (bus.D_RDValid !== exp_rdv) begin bad++; $display("FAIL rnd_rdvalid n=%0d got=%b exp=%b", n, bus.D_RDValid, exp_rdv); end
            total++; if (bus.D_RD !== exp_drd) begin bad++; $display("FAIL rnd_rd n=%0d got=%h exp=%h", n, bus.D_RD, exp_drd); end
            // advance the reference model by one clock
            exp_rdv = dg && !bus.D_WE;
            if (exp_rdv) exp_drd = ref_mem[bus.D_A[7:0]];
            if (dg && bus.D_WE) ref_mem[bus.D_A[7:0]] = bus.D_WD;
            if (pg && bus.P_WE) ref_mem[bus.P_A[7:0]] = bus.P_WD;
            done = dg;
            if (dg) begin
                waited = 0; last_forced = forced;
            end else if (bus.D_Valid) begin
                waited = (waited < MAX_WAIT) ? waited + 1 : MAX_WAIT; last_forced = 0;
            end else begin
                waited = 0; last_forced = 0;
            end
        end
        @(negedge CLK);
        clear_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'(i * 7 + 3);
        clear_inputs();
        RST = 1'b0;
        test_reset();
        test_pipe_write();
        test_dbg_read();
        test_starve();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
